// File: rtl/sync_fifo.sv
// Single-clock FIFO: words pushed at the tail are popped from the head in order.
// q is registered and holds the word from the most recent accepted pop.
module sync_fifo #(
  parameter int DATAWIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       wr_en,
  input  logic [DATAWIDTH-1:0]       d,
  input  logic                       rd_en,
  output logic [DATAWIDTH-1:0]       q,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wp;
  logic [AW-1:0]        rp;
  logic                 push_ok;
  logic                 pop_ok;
  logic [CW-1:0]        count_nxt;

  // Handshake: a push is taken on any edge where wr_en is high and a slot is
  // free (or the head is leaving in the same cycle); a pop is taken on any edge
  // where rd_en is high and the FIFO holds a word. Nothing is held over: a
  // rejected request is dropped and reported by a one-cycle pulse.
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | rd_en);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_nxt = count - CW'(1);
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge Clk) begin
    if (push_ok)
      mem[wp] <= d;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wp        <= '0;
      rp        <= '0;
      q         <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok)
        wp <= wp + AW'(1);
      if (pop_ok) begin
        q  <= mem[rp];
        rp <= rp + AW'(1);
      end
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      empty     <= (count_nxt == '0);
      overflow  <= wr_en & full & ~rd_en;
      underflow <= rd_en & empty;
    end
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer for the datapath register library. A producer writes words at the tail; a consumer reads them from the head in order. It decouples two datapath stages that cannot be stalled in lockstep. Occupancy is exposed so a scheduler can throttle either side.

## Interface

Parameters:
- DATAWIDTH, 16, bit width of each stored word.
- DEPTH, 4, number of storage entries; power of two, ≥ 2.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  push request for the current cycle.
- d  input  DATAWIDTH  word to push; sampled on the edge where the push is accepted.
- rd_en  input  1  pop request for the current cycle.
- q  output  DATAWIDTH  registered head word from the most recent accepted pop.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- overflow  output  1  one-cycle pulse: a push was rejected.
- underflow  output  1  one-cycle pulse: a pop was rejected.

## Operation

- **Storage:** DEPTH × DATAWIDTH array, write pointer wp, read pointer rp.
  - Each pointer is log2(DEPTH) bits wide.
  - Both wrap naturally from DEPTH-1 to 0.
- **Pop acceptance:** pop_ok = rd_en & !empty.
- **Push acceptance:** push_ok = wr_en & (!full | rd_en).
  - When full, a simultaneous pop frees the head slot, so the push is accepted in the same cycle.
- **On push_ok:** mem[wp] <= d; wp <= wp+1.
- **On pop_ok:** q <= mem[rp]; rp <= rp+1.
  - q holds its value on every cycle without pop_ok.
- **count update:**
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- **Flags:** full and empty are registered, derived from the next-state count; never combinational from wr_en/rd_en.
- **Push while empty plus pop in same cycle:**
  - The pop is rejected; there is no bypass.
  - underflow pulses.
  - The pushed word is stored; count becomes 1.
- **overflow:** pulses for exactly one cycle on wr_en & full & !rd_en.
- **underflow:** pulses for exactly one cycle on rd_en & empty.
- **Rejected operations:** never alter memory, pointers, count or q.
- **Reset (Rst high, any time, asynchronous):**
  - Outputs: q=0, count=0, empty=1, full=0, overflow=0, underflow=0.
  - Pointers: wp=rp=0.
  - Memory contents are not cleared and are don't-care.
  - Reset asserted mid-transfer discards all stored words.
  - The first edge after Rst deasserts behaves as from an empty FIFO.

## Timing

- **Write-to-read latency:**
  - A word pushed at edge N is poppable at edge N+1.
  - It appears on q after the popping edge, i.e. at N+1 at the earliest.
- **Read latency:** q is valid one cycle after rd_en is sampled high with empty low.
- **Flag update:** full, empty and count all change on the same edge as the accepted operation.
- **Sustained throughput:** one push and one pop per cycle at any occupancy, including full.
- **Pulse alignment:** overflow and underflow are registered and assert for the cycle following the offending request.

## Test plan

- **Reset state:** assert Rst asynchronously between edges → immediately q=0, count=0, empty=1, full=0; both pulses low.
- **Fill, overfill, drain** (DEPTH=4):
  - Push 0x0001..0x0004 → full=1, count=4.
  - Push 0x0005 with rd_en=0 → overflow pulses one cycle; count stays 4.
  - Pop four times → q = 0x0001, 0x0002, 0x0003, 0x0004 in order; empty=1 after the fourth pop.
- **Underflow:**
  - Pop while empty → underflow pulses one cycle; q unchanged; count=0.
  - Push 0x00AA with rd_en=1 while empty → count=1, underflow=1; the next pop gives q=0x00AA.
- **Simultaneous push/pop when full:**
  - Hold 0x0011..0x0014, then wr_en=rd_en=1 with d=0x0015 → q=0x0011, count stays 4, no overflow.
  - Drain → 0x0012, 0x0013, 0x0014, 0x0015.
- **Wrap-around:**
  - Stream 10 words 0x0100..0x0109, popping each one cycle after it is pushed.
  - Required: q sequence matches exactly, count never exceeds 2, and pointers wrap twice without data loss.
- **Reset mid-operation:**
  - With count=3, pulse Rst for half a cycle → count=0, empty=1.
  - A subsequent pop → underflow; the following push/pop of 0x0BEE → q=0x0BEE.
